// File: rtl/aw_signals_waiver_ctrl.sv
// Assertion-waiver controller: derives per-checker assertion enables for the
// video-sync-out, RAM-control and MUX-output checkers of the video scaler.
module aw_signals_waiver_ctrl #(
   parameter int STABLE_CNT = 10,
   parameter int CNT_W      = 4
) (
   input  logic I_CLK,
   input  logic I_RSTN,
   input  logic I_VSO_WAIVER_EN,
   input  logic I_RAM_WAIVER_EN,
   input  logic I_MUX_WAIVER_EN,
   input  logic I_VSYNC_AFTER_SCALE,
   input  logic I_CS1,
   input  logic I_CS2,
   input  logic I_CS3,
   input  logic I_CS4,
   input  logic I_MIRROR_MODE_CAP,
   input  logic I_BLUR_MODE_CAP,
   output logic O_VSO_ASSERT_EN,
   output logic O_RAM_ASSERT_EN,
   output logic O_MUX_ASSERT_EN
);

   localparam logic [CNT_W-1:0] STABLE_MAX = CNT_W'(STABLE_CNT);

   typedef enum logic [1:0] {WAIT_VS, FIRST_VS, RUN} vso_state_t;

   vso_state_t       vso_state;
   logic             armed;
   logic             vso_q;
   logic             ram_q;
   logic             seen_low;
   logic             prev;
   logic [CNT_W-1:0] cnt;
   logic             stable;
   logic             seen_stable;
   logic             cs_any;
   logic             scaler_on;

   assign cs_any    = I_CS1 | I_CS2 | I_CS3 | I_CS4;
   assign scaler_on = I_MIRROR_MODE_CAP | I_BLUR_MODE_CAP;

   always_ff @(posedge I_CLK or negedge I_RSTN) begin
      if (!I_RSTN) armed <= 1'b0;
      else         armed <= 1'b1;
   end

   // The first VSYNC pulse after arming is legitimate; later pulses are waived.
   always_ff @(posedge I_CLK or negedge I_RSTN) begin
      if (!I_RSTN) begin
         vso_state <= WAIT_VS;
         vso_q     <= 1'b0;
      end else if (!I_VSO_WAIVER_EN) begin
         vso_state <= WAIT_VS;
         vso_q     <= 1'b0;
      end else begin
         case (vso_state)
            WAIT_VS: begin
               vso_q <= I_VSYNC_AFTER_SCALE;
               if (I_VSYNC_AFTER_SCALE) vso_state <= FIRST_VS;
            end
            FIRST_VS: begin
               vso_q <= 1'b1;
               if (!I_VSYNC_AFTER_SCALE) vso_state <= RUN;
            end
            RUN:     vso_q <= ~I_VSYNC_AFTER_SCALE;
            default: begin
               vso_state <= WAIT_VS;
               vso_q     <= 1'b0;
            end
         endcase
      end
   end

   // Chip selects held from reset release are not waived until they first drop.
   always_ff @(posedge I_CLK or negedge I_RSTN) begin
      if (!I_RSTN) begin
         ram_q    <= 1'b0;
         seen_low <= 1'b0;
      end else begin
         ram_q    <= ~cs_any | ~seen_low;
         seen_low <= seen_low | ~cs_any;
      end
   end

   always_ff @(posedge I_CLK or negedge I_RSTN) begin
      if (!I_RSTN) begin
         prev        <= 1'b0;
         cnt         <= '0;
         stable      <= 1'b0;
         seen_stable <= 1'b0;
      end else begin
         prev        <= scaler_on;
         seen_stable <= seen_stable | stable;
         if (scaler_on != prev) begin
            cnt    <= '0;
            stable <= 1'b0;
         end else begin
            if (cnt < STABLE_MAX) cnt <= cnt + 1'b1;
            if (cnt >= STABLE_MAX) stable <= 1'b1;
         end
      end
   end

   assign O_VSO_ASSERT_EN = armed & I_VSO_WAIVER_EN & vso_q;
   assign O_RAM_ASSERT_EN = armed & I_RAM_WAIVER_EN & ram_q;
   assign O_MUX_ASSERT_EN = armed & I_MUX_WAIVER_EN & (stable | ~seen_stable);

endmodule

// File: tb/tb_aw_signals_waiver_ctrl.sv
// Scoreboard bench: stimulus pushes hand-derived expected enables after each
// edge; a negedge monitor pops and compares them against the DUT.
module tb_aw_signals_waiver_ctrl;

   logic clk = 1'b0;
   logic rst_n;
   logic vso_en, ram_en, mux_en;
   logic vsync, cs1, cs2, cs3, cs4, mirror, blur;
   logic o_vso, o_ram, o_mux;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic vso;
      logic ram;
      logic mux;
   } exp_t;

   exp_t exp_q[$];

   always #5 clk = ~clk;

   aw_signals_waiver_ctrl dut (
      .I_CLK               (clk),
      .I_RSTN              (rst_n),
      .I_VSO_WAIVER_EN     (vso_en),
      .I_RAM_WAIVER_EN     (ram_en),
      .I_MUX_WAIVER_EN     (mux_en),
      .I_VSYNC_AFTER_SCALE (vsync),
      .I_CS1               (cs1),
      .I_CS2               (cs2),
      .I_CS3               (cs3),
      .I_CS4               (cs4),
      .I_MIRROR_MODE_CAP   (mirror),
      .I_BLUR_MODE_CAP     (blur),
      .O_VSO_ASSERT_EN     (o_vso),
      .O_RAM_ASSERT_EN     (o_ram),
      .O_MUX_ASSERT_EN     (o_mux)
   );

   // Wait for the next edge, queue the expectation for that edge, and return
   // just after the following negedge so new inputs never race the monitor.
   task automatic tick(input logic ev, input logic er, input logic em);
      exp_t e;
      @(posedge clk);
      #1;
      e.vso = ev;
      e.ram = er;
      e.mux = em;
      exp_q.push_back(e);
      @(negedge clk);
      #1;
   endtask

   task automatic chk_now(input string name, input logic act, input logic req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %b, expected %b at %0t", name, act, req, $time);
      end
   endtask

   // Monitor
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks += 3;
            if (o_vso !== e.vso) begin
               errors++;
               $display("FAIL vso_en: got %b, expected %b at %0t", o_vso, e.vso, $time);
            end
            if (o_ram !== e.ram) begin
               errors++;
               $display("FAIL ram_en: got %b, expected %b at %0t", o_ram, e.ram, $time);
            end
            if (o_mux !== e.mux) begin
               errors++;
               $display("FAIL mux_en: got %b, expected %b at %0t", o_mux, e.mux, $time);
            end
         end
      end
   end

   initial begin
      rst_n  = 1'b0;
      vso_en = 1'b1; ram_en = 1'b1; mux_en = 1'b1;
      vsync  = 1'b0; cs1 = 1'b1; cs2 = 1'b0; cs3 = 1'b0; cs4 = 1'b0;
      mirror = 1'b0; blur = 1'b0;
      #1;
      chk_now("reset_vso", o_vso, 1'b0);
      chk_now("reset_ram", o_ram, 1'b0);
      chk_now("reset_mux", o_mux, 1'b0);
      tick(1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;

      // Phase 1: VSYNC at 20 and 100, CS1 high from reset to edge 10,
      // CS2 at 30..32, MIRROR rises at edge 50 (after stable at edge 11).
      for (int e = 1; e <= 115; e++) begin
         vsync  = (e >= 20 && e <= 24) || (e >= 100 && e <= 104);
         cs1    = (e <= 10);
         cs2    = (e >= 30 && e <= 32);
         mirror = (e >= 50);
         tick((e >= 20) && !(e >= 100 && e <= 104),
              !(e >= 30 && e <= 32),
              !(e >= 50 && e <= 60));
      end

      // Mid-frame reset: outputs drop at once, without waiting for an edge.
      vsync = 1'b1;
      rst_n = 1'b0;
      #1;
      chk_now("midrst_vso", o_vso, 1'b0);
      chk_now("midrst_ram", o_ram, 1'b0);
      chk_now("midrst_mux", o_mux, 1'b0);
      tick(1'b0, 1'b0, 1'b0);
      vsync  = 1'b0;
      mirror = 1'b0;
      ram_en = 1'b0;
      rst_n  = 1'b1;

      // Phase 2: VSO re-waits; RAM disabled with CS3 activity, then re-enabled
      // with CS4 pulse; BLUR rises at 20; VSO disabled 36..39, re-armed by
      // a fresh VSYNC at 45.
      for (int f = 1; f <= 50; f++) begin
         vsync  = (f >= 10 && f <= 12) || (f >= 45 && f <= 46);
         cs3    = (f >= 5 && f <= 7);
         cs4    = (f >= 43 && f <= 44);
         blur   = (f >= 20);
         vso_en = !(f >= 36 && f <= 39);
         ram_en = (f >= 41);
         tick((f >= 10 && f <= 35) || (f >= 45),
              (f >= 41) && !(f >= 43 && f <= 44),
              !(f >= 20 && f <= 30));
      end

      @(posedge clk);
      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/aw_signals_waiver_ctrl.md
# aw_signals_waiver_ctrl

Synthesizable assertion-waiver controller that produces one assertion-enable level for each of three checkers: video-sync-out, RAM control and MUX output. It sits beside the video scaler datapath, observes scaled VSYNC, the four SRAM chip selects and the mirror/blur mode captures, and drops each checker's enable during windows where that checker's assertions are known to be invalid. All enables are forced low in reset and held low for any channel whose waiver enable input is low.

## Interface
- STABLE_CNT, 10, consecutive equal samples of scaler-on required before MUX mode counts as stable (counter width 4 bits).

- I_CLK  in  1  system clock, all state on rising edge.
- I_RSTN  in  1  reset, asynchronous, active-low.
- I_VSO_WAIVER_EN  in  1  video-sync-out channel enable; 0 keeps O_VSO_ASSERT_EN at 0.
- I_RAM_WAIVER_EN  in  1  RAM-control channel enable.
- I_MUX_WAIVER_EN  in  1  MUX-output channel enable.
- I_VSYNC_AFTER_SCALE  in  1  scaled vertical sync, active-high.
- I_CS1, I_CS2, I_CS3, I_CS4  in  1 each  SRAM chip selects, active-high.
- I_MIRROR_MODE_CAP  in  1  captured mirror mode.
- I_BLUR_MODE_CAP  in  1  captured blur mode.
- O_VSO_ASSERT_EN  out  1  video-sync-out checker assertions enabled.
- O_RAM_ASSERT_EN  out  1  RAM-control checker assertions enabled.
- O_MUX_ASSERT_EN  out  1  MUX-output checker assertions enabled.

## Operation
- Every channel has an `armed` flag: cleared by reset, set on the first rising edge of I_CLK after I_RSTN deasserts. Outputs are 0 while not armed or while the channel's waiver enable is 0.
- Video-sync-out FSM, states WAIT_VS, FIRST_VS, RUN:
  - Reset goes to WAIT_VS; output 0.
  - WAIT_VS to FIRST_VS when VSYNC is sampled 1; output 1.
  - FIRST_VS to RUN when VSYNC is sampled 0. The first VSYNC pulse is not waived.
  - In RUN, output = NOT VSYNC as sampled at that edge. Every later VSYNC-high period is waived.
  - Waiver enable 0 holds the FSM in WAIT_VS.
- RAM control:
  - cs_any = CS1 | CS2 | CS3 | CS4.
  - Once armed, output = NOT cs_any as sampled at the edge.
  - Exception: if cs_any has been high continuously since reset release, the output stays 1 until cs_any is first sampled low. A `seen_low` flag tracks this; only a cs_any rising edge after that waives.
- MUX output:
  - scaler_on = MIRROR | BLUR.
  - prev <= scaler_on.
  - cnt <= 0 if scaler_on != prev; otherwise cnt + 1, saturating at STABLE_CNT.
  - stable <= 1 if scaler_on == prev and cnt >= STABLE_CNT; stable <= 0 if scaler_on != prev; otherwise stable holds.
  - seen_stable is set when stable = 1 and cleared only by reset.
  - O_MUX_ASSERT_EN = armed AND I_MUX_WAIVER_EN AND (stable OR NOT seen_stable). Enabled from arming until stable first falls, then it follows stable.
- Reset mid-operation: all flags, counters and FSM states clear immediately and all outputs go to 0.

## Timing
- VSO and RAM outputs are registered: a change on an input sampled at edge N appears after edge N, with one cycle of latency.
- The MUX output is combinational from registers only. It changes after the edge that updates stable or seen_stable.
- With scaler_on constant from reset, stable rises at the 11th edge after reset release.
- After a scaler_on change sampled at edge K, stable falls after K and rises after edge K+11, provided there is no further change.
- Simultaneous events on different channels are independent. Waiver enable inputs are treated as quasi-static.

## Test plan
- Reset, waiver enables all 1, no activity -> VSO output 0; RAM output 1 and MUX output 1 from the first edge after reset.
- VSYNC pulses of 5 cycles at cycles 20 and 100 -> VSO output 1 during the first pulse (1-cycle latency), 0 for 5 cycles after cycle 100, back to 1 one cycle after VSYNC falls.
- CS2 high for 3 cycles at cycle 30 -> RAM output 0 for exactly 3 cycles, delayed by 1; CS1 held high from reset to cycle 10 -> RAM output stays 1 throughout.
- MIRROR toggles 0 to 1 at cycle 50 after stable has been reached -> MUX output 0 from cycle 51 to cycle 61, 1 again after edge 61.
- I_RAM_WAIVER_EN = 0 with CS activity -> O_RAM_ASSERT_EN stays 0.
- I_RSTN pulsed low mid-frame -> all outputs go to 0 immediately; the VSO channel re-waits for VSYNC after release.
